// File: rtl/div_ctrl.sv
// div_ctrl: sequences one divide at a time between the execute stage and the
// signed/unsigned divider cores. It issues operands on the selected core's
// stream channels, waits for the result, and holds it until the stage takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation; accepts req when flush is low
// SEND  | operands offered to the selected core until both channels take them
// WAIT  | waiting for the selected core's result; kill drops it silently
// DONE  | quotient/remainder held with res_valid until ack or flush
module div_ctrl #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req,
    input  logic            req_signed,
    input  logic [DW-1:0]   dividend,
    input  logic [DW-1:0]   divisor,
    input  logic            ack,
    input  logic            flush,
    output logic            busy,
    output logic            res_valid,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            sdiv_dividend_tvalid,
    input  logic            sdiv_dividend_tready,
    output logic            sdiv_divisor_tvalid,
    input  logic            sdiv_divisor_tready,
    output logic            udiv_dividend_tvalid,
    input  logic            udiv_dividend_tready,
    output logic            udiv_divisor_tvalid,
    input  logic            udiv_divisor_tready,
    output logic [DW-1:0]   div_dividend_tdata,
    output logic [DW-1:0]   div_divisor_tdata,
    input  logic            sdiv_dout_tvalid,
    input  logic [2*DW-1:0] sdiv_dout_tdata,
    input  logic            udiv_dout_tvalid,
    input  logic [2*DW-1:0] udiv_dout_tdata
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic            op_signed;
    logic [DW-1:0]   op_a, op_b;
    logic [DW-1:0]   quo_q, rem_q;
    logic            sent_a, sent_b, kill;
    logic            a_valid, b_valid, a_ready, b_ready, a_hs, b_hs;
    logic            dout_v;
    logic [2*DW-1:0] dout_data;

    // tvalid depends only on registered state, so a flush can never retract it
    assign a_valid   = (state == SEND) && !sent_a;
    assign b_valid   = (state == SEND) && !sent_b;
    assign a_ready   = op_signed ? sdiv_dividend_tready : udiv_dividend_tready;
    assign b_ready   = op_signed ? sdiv_divisor_tready  : udiv_divisor_tready;
    assign a_hs      = a_valid && a_ready;
    assign b_hs      = b_valid && b_ready;
    assign dout_v    = op_signed ? sdiv_dout_tvalid : udiv_dout_tvalid;
    assign dout_data = op_signed ? sdiv_dout_tdata  : udiv_dout_tdata;

    assign sdiv_dividend_tvalid = a_valid && op_signed;
    assign sdiv_divisor_tvalid  = b_valid && op_signed;
    assign udiv_dividend_tvalid = a_valid && !op_signed;
    assign udiv_divisor_tvalid  = b_valid && !op_signed;
    assign div_dividend_tdata   = op_a;
    assign div_divisor_tdata    = op_b;
    assign busy                 = (state != IDLE);
    assign res_valid            = (state == DONE);
    assign quotient             = quo_q;
    assign remainder            = rem_q;

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req && !flush) state_n = SEND;
            SEND: if ((sent_a || a_hs) && (sent_b || b_hs)) state_n = WAIT;
            WAIT: if (dout_v) state_n = (kill || flush) ? IDLE : DONE;
            DONE: if (ack || flush) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, operand latches, handshake flags, kill and result capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            op_signed <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            sent_a    <= 1'b0;
            sent_b    <= 1'b0;
            kill      <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req && !flush) begin
                        op_signed <= req_signed;
                        op_a      <= dividend;
                        op_b      <= divisor;
                        sent_a    <= 1'b0;
                        sent_b    <= 1'b0;
                        kill      <= 1'b0;
                    end
                end
                SEND: begin
                    if (a_hs)  sent_a <= 1'b1;
                    if (b_hs)  sent_b <= 1'b1;
                    if (flush) kill   <= 1'b1;
                end
                WAIT: begin
                    if (flush) kill <= 1'b1;
                    // a killed result is never latched, so the last reported one stays put
                    if (dout_v && !(kill || flush)) begin
                        quo_q <= dout_data[2*DW-1:DW];
                        rem_q <= dout_data[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a small behavioural model of
// the two divider cores.
module tb_div_ctrl;

    localparam int DW       = 32;
    localparam int CORE_LAT = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req, req_signed, ack, flush;
    logic [DW-1:0]   dividend, divisor;
    logic            busy, res_valid;
    logic [DW-1:0]   quotient, remainder;
    logic            sdiv_dividend_tvalid, sdiv_divisor_tvalid;
    logic            udiv_dividend_tvalid, udiv_divisor_tvalid;
    logic            sdiv_dividend_tready, sdiv_divisor_tready;
    logic            udiv_dividend_tready, udiv_divisor_tready;
    logic [DW-1:0]   div_dividend_tdata, div_divisor_tdata;
    logic            sdiv_dout_tvalid, udiv_dout_tvalid;
    logic [2*DW-1:0] sdiv_dout_tdata, udiv_dout_tdata;

    logic [2*DW-1:0] s_res, u_res;
    logic            s_dv, u_dv, u_spur;
    logic            m_a, m_b, m_sgn, ha, hb;
    int              m_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_signed(req_signed),
        .dividend(dividend), .divisor(divisor), .ack(ack), .flush(flush),
        .busy(busy), .res_valid(res_valid), .quotient(quotient), .remainder(remainder),
        .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_dividend_tready(sdiv_dividend_tready),
        .sdiv_divisor_tvalid(sdiv_divisor_tvalid),   .sdiv_divisor_tready(sdiv_divisor_tready),
        .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_dividend_tready(udiv_dividend_tready),
        .udiv_divisor_tvalid(udiv_divisor_tvalid),   .udiv_divisor_tready(udiv_divisor_tready),
        .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
        .sdiv_dout_tvalid(sdiv_dout_tvalid), .sdiv_dout_tdata(sdiv_dout_tdata),
        .udiv_dout_tvalid(udiv_dout_tvalid), .udiv_dout_tdata(udiv_dout_tdata)
    );

    assign sdiv_dout_tdata  = s_res;
    assign udiv_dout_tdata  = u_res;
    assign sdiv_dout_tvalid = s_dv;
    assign udiv_dout_tvalid = u_dv | u_spur;

    // Core model: evaluated on the falling edge so it sees settled handshakes;
    // dout_tvalid pulses CORE_LAT cycles after the cycle the last operand is taken + 1.
    always @(negedge clk) begin
        s_dv <= 1'b0;
        u_dv <= 1'b0;
        if (!resetn) begin
            m_a   <= 1'b0;
            m_b   <= 1'b0;
            m_cnt <= 0;
        end else begin
            ha = (sdiv_dividend_tvalid && sdiv_dividend_tready) ||
                 (udiv_dividend_tvalid && udiv_dividend_tready);
            hb = (sdiv_divisor_tvalid && sdiv_divisor_tready) ||
                 (udiv_divisor_tvalid && udiv_divisor_tready);
            if (m_cnt == 1) begin
                if (m_sgn) s_dv <= 1'b1;
                else       u_dv <= 1'b1;
            end
            if (m_cnt > 0) m_cnt <= m_cnt - 1;
            if ((m_a || ha) && (m_b || hb)) begin
                m_a   <= 1'b0;
                m_b   <= 1'b0;
                m_cnt <= CORE_LAT + 1;
                m_sgn <= sdiv_dividend_tvalid || sdiv_divisor_tvalid;
            end else begin
                m_a <= m_a || ha;
                m_b <= m_b || hb;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until res_valid is seen, bounded
    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [3:0] tv();
        return {sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                udiv_dividend_tvalid, udiv_divisor_tvalid};
    endfunction

    task automatic set_ready(input logic v);
        sdiv_dividend_tready = v;
        sdiv_divisor_tready  = v;
        udiv_dividend_tready = v;
        udiv_divisor_tready  = v;
    endtask

    initial begin
        int n;
        logic seen;
        resetn = 1'b0; req = 1'b0; req_signed = 1'b0; ack = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0; u_spur = 1'b0;
        s_res = '0; u_res = '0;
        set_ready(1'b1);
        tick(); tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_tvalid", tv(), 4'b0000);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_tdata", {div_dividend_tdata, div_divisor_tdata}, 0);
        resetn = 1'b1;
        tick();

        // signed -7/2, treadies high
        s_res = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
        u_res = 64'h1111_2222_3333_4444;
        req = 1'b1; req_signed = 1'b1; dividend = 32'hFFFF_FFF9; divisor = 32'h0000_0002;
        tick();                                   // T+1
        req = 1'b0;
        chk("s1_tvalid_t1", tv(), 4'b1100);
        chk("s1_tdata", {div_dividend_tdata, div_divisor_tdata}, 64'hFFFF_FFF9_0000_0002);
        tick();                                   // T+2
        chk("s1_tvalid_t2", tv(), 4'b0000);
        chk("s1_busy_t2", busy, 1);
        tick();                                   // T+3
        u_spur = 1'b1;
        tick();                                   // T+4
        u_spur = 1'b0;
        chk("s1_spur_ignored", {busy, res_valid}, 2'b10);
        tick();                                   // T+5
        chk("s1_rv_t5", res_valid, 0);
        tick();                                   // T+6
        chk("s1_rv_t6", res_valid, 1);
        chk("s1_quotient", quotient, 32'hFFFF_FFFD);
        chk("s1_remainder", remainder, 32'hFFFF_FFFF);
        tick();                                   // T+7
        chk("s1_hold", {res_valid, quotient}, {1'b1, 32'hFFFF_FFFD});
        ack = 1'b1;
        tick();                                   // T+8
        ack = 1'b0;
        chk("s1_idle_after_ack", {busy, res_valid}, 2'b00);

        // unsigned 0xFFFFFFFF/16, divisor_tready low for 4 cycles
        u_res = {32'h0FFF_FFFF, 32'h0000_000F};
        s_res = 64'h5555_6666_7777_8888;
        udiv_divisor_tready = 1'b0;
        req = 1'b1; req_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'h0000_0010;
        tick();                                   // T+1
        req = 1'b0;
        chk("u2_tvalid_t1", tv(), 4'b0011);
        tick();                                   // T+2
        chk("u2_tvalid_t2", tv(), 4'b0001);
        tick(); tick(); tick();                   // T+5
        chk("u2_tvalid_t5", tv(), 4'b0001);
        chk("u2_tdata_stable", {div_dividend_tdata, div_divisor_tdata}, 64'hFFFF_FFFF_0000_0010);
        udiv_divisor_tready = 1'b1;
        tick();                                   // T+6
        chk("u2_tvalid_t6", tv(), 4'b0000);
        wait_res(n);
        chk("u2_latency", n, 4);
        chk("u2_quotient", quotient, 32'h0FFF_FFFF);
        chk("u2_remainder", remainder, 32'h0000_000F);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // flush in WAIT
        u_res = 64'hDEAD_BEEF_CAFE_F00D;
        req = 1'b1; req_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
        tick();                                   // T+1
        req = 1'b0;
        tick();                                   // T+2
        tick();                                   // T+3
        flush = 1'b1;
        tick();                                   // T+4
        flush = 1'b0;
        chk("f3_busy_t4", {busy, res_valid}, 2'b10);
        tick();                                   // T+5
        chk("f3_busy_t5", {busy, res_valid}, 2'b10);
        tick();                                   // T+6
        chk("f3_idle_t6", {busy, res_valid}, 2'b00);
        tick();
        chk("f3_no_res", res_valid, 0);
        u_res = {32'd14, 32'd2};
        req = 1'b1; dividend = 32'd100; divisor = 32'd7;
        tick();
        req = 1'b0;
        wait_res(n);
        chk("f3_new_latency", n, 5);
        chk("f3_new_result", {quotient, remainder}, {32'd14, 32'd2});
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // back-to-back with req held through ack
        s_res = {32'd6, 32'd2};
        req = 1'b1; req_signed = 1'b1; dividend = 32'd20; divisor = 32'd3;
        tick();                                   // T+1
        wait_res(n);                              // T+6
        chk("b4_first_latency", n, 5);
        chk("b4_first_result", {quotient, remainder}, {32'd6, 32'd2});
        s_res = {32'h8000_0000, 32'h0000_0000};
        tick();                                   // T+7
        chk("b4_not_overwritten", {res_valid, quotient, remainder}, {1'b1, 32'd6, 32'd2});
        ack = 1'b1;
        tick();                                   // T+8
        ack = 1'b0;
        chk("b4_no_retrigger", {busy, res_valid}, 2'b00);
        dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF;
        tick();                                   // T+9
        req = 1'b0;
        chk("b4_second_accept", {busy, tv()}, {1'b1, 4'b1100});
        chk("b4_second_tdata", {div_dividend_tdata, div_divisor_tdata}, 64'h8000_0000_FFFF_FFFF);
        wait_res(n);
        chk("b4_second_latency", n, 5);
        chk("b4_second_result", {quotient, remainder}, {32'h8000_0000, 32'h0000_0000});
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // flush in SEND with tready low
        set_ready(1'b0);
        u_res = 64'h0BAD_0BAD_0BAD_0BAD;
        req = 1'b1; req_signed = 1'b0; dividend = 32'd9; divisor = 32'd4;
        tick();                                   // T+1
        req = 1'b0;
        flush = 1'b1;
        tick();                                   // T+2
        flush = 1'b0;
        chk("f5_tvalid_held_t2", {busy, tv()}, {1'b1, 4'b0011});
        tick();                                   // T+3
        chk("f5_tvalid_held_t3", tv(), 4'b0011);
        set_ready(1'b1);
        tick();                                   // T+4
        chk("f5_wait", {busy, tv()}, {1'b1, 4'b0000});
        n = 0;
        seen = 1'b0;
        while (busy && n < 30) begin
            tick();
            n++;
            if (res_valid) seen = 1'b1;
        end
        chk("f5_drain_cycles", n, 4);
        chk("f5_res_never", seen, 0);
        chk("f5_quotient_kept", quotient, 32'h8000_0000);

        // flush in IDLE does not block... nor accept
        req = 1'b1; flush = 1'b1;
        tick();
        req = 1'b0; flush = 1'b0;
        chk("idle_flush_no_accept", busy, 0);

        // reset during SEND
        set_ready(1'b0);
        req = 1'b1; req_signed = 1'b1; dividend = 32'd1; divisor = 32'd1;
        tick();                                   // T+1
        req = 1'b0;
        chk("r6_in_send", tv(), 4'b1100);
        resetn = 1'b0;
        tick();                                   // T+2
        chk("r6_after_reset", {busy, res_valid, tv()}, 6'b0);
        resetn = 1'b1;
        set_ready(1'b1);
        tick();

        // recovery op, leave DONE with flush
        s_res = {32'hFFFF_FFF2, 32'h0000_0002};
        req = 1'b1; req_signed = 1'b1; dividend = 32'd100; divisor = 32'hFFFF_FFF9;
        tick();
        req = 1'b0;
        wait_res(n);
        chk("r6_recovery_latency", n, 5);
        chk("r6_recovery_result", {quotient, remainder}, {32'hFFFF_FFF2, 32'h0000_0002});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("done_flush_exit", {busy, res_valid}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
